// File: rtl/swivm_lsu_if.sv
// Memory-side bus of the load/store unit: word-aligned request with byte-lane
// enables, and a single-cycle acknowledge carrying the full read word.
interface swivm_lsu_if #(
  parameter int unsigned AW = 16
) ();
  logic          o_mem_req;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [3:0]    o_mem_be;
  logic [31:0]   o_mem_wdata;
  logic          i_mem_ack;
  logic [31:0]   i_mem_rdata;

  modport master (
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
    input  i_mem_ack, i_mem_rdata
  );

  modport slave (
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
    output i_mem_ack, i_mem_rdata
  );
endinterface

// File: rtl/swivm_lsu.sv
// Load/store unit: validates a core access, runs one memory transaction with
// lane placement / extraction and an ack timeout, then pulses o_done.
module swivm_lsu #(
  parameter int unsigned AW      = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic [1:0]  o_errcode,
  swivm_lsu_if.master mem
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_RSVD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic [1:0] E_SIZE    = 2'b00;
  localparam logic [1:0] E_ALIGN   = 2'b01;
  localparam logic [1:0] E_RANGE   = 2'b10;
  localparam logic [1:0] E_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e        state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    errcode_q, errcode_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          sgn_q, sgn_d;
  logic [1:0]    lane_q, lane_d;

  logic        bad_size, misalign, out_of_range;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic        timeout_hit;

  // Acceptance checks and store lane placement, evaluated on the raw request.
  always_comb begin
    bad_size     = (i_size == SZ_RSVD);
    misalign     = ((i_size == SZ_HALF) && i_addr[0]) ||
                   ((i_size == SZ_WORD) && (i_addr[1:0] != 2'b00));
    out_of_range = ((i_addr >> AW) != 32'd0);
    case (i_size)
      SZ_BYTE: begin
        acc_be    = 4'b0001 << i_addr[1:0];
        acc_wdata = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        acc_be    = 4'b0011 << i_addr[1:0];
        acc_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        acc_be    = 4'b1111;
        acc_wdata = i_wdata;
      end
    endcase
  end

  // Little-endian lane extraction and extension of the returned word.
  always_comb begin
    ld_byte = mem.i_mem_rdata[{lane_q, 3'b000} +: 8];
    ld_half = lane_q[1] ? mem.i_mem_rdata[31:16] : mem.i_mem_rdata[15:0];
    case (size_q)
      SZ_BYTE: ld_ext = {{24{sgn_q & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_ext = {{16{sgn_q & ld_half[15]}}, ld_half};
      default: ld_ext = mem.i_mem_rdata;
    endcase
  end

  // Fires on the TIMEOUT-th consecutive BUS cycle without an ack.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    errcode_d   = errcode_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    wait_cnt_d  = wait_cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    lane_d      = lane_q;
    case (state_q)
      IDLE: begin
        if (i_req) begin
          busy_d = 1'b1;
          we_d   = i_we;
          size_d = i_size;
          sgn_d  = i_signed;
          lane_d = i_addr[1:0];
          if (bad_size || misalign || out_of_range) begin
            state_d   = RESP;
            done_d    = 1'b1;
            err_d     = 1'b1;
            errcode_d = bad_size ? E_SIZE : (misalign ? E_ALIGN : E_RANGE);
          end else begin
            state_d     = BUS;
            err_d       = 1'b0;
            errcode_d   = 2'b00;
            mem_req_d   = 1'b1;
            mem_we_d    = i_we;
            mem_addr_d  = {i_addr[AW-1:2], 2'b00};
            mem_be_d    = acc_be;
            mem_wdata_d = acc_wdata;
            wait_cnt_d  = '0;
          end
        end
      end
      BUS: begin
        if (mem.i_mem_ack) begin
          state_d   = RESP;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!we_q) rdata_d = ld_ext;
        end else if (timeout_hit) begin
          state_d   = RESP;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = 1'b1;
          errcode_d = E_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      errcode_q   <= 2'b00;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      wait_cnt_q  <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      sgn_q       <= 1'b0;
      lane_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      errcode_q   <= errcode_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      lane_q      <= lane_d;
    end
  end

  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_rdata         = rdata_q;
  assign o_err           = err_q;
  assign o_errcode       = errcode_q;
  assign mem.o_mem_req   = mem_req_q;
  assign mem.o_mem_we    = mem_we_q;
  assign mem.o_mem_addr  = mem_addr_q;
  assign mem.o_mem_be    = mem_be_q;
  assign mem.o_mem_wdata = mem_wdata_q;

endmodule

// File: doc/swivm_lsu.md
SWIVM_LSU -- requirements
Module: swivm_lsu

Interface
REQ-001 SHALL have parameter AW, default 16: physical address width in bits, legal range 12..32.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum wait cycles for i_mem_ack; 0 disables the timeout.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_req, input, 1 bit: core access request, sampled only while o_busy=0.
REQ-006 SHALL have port i_we, input, 1 bit: 1 means store, 0 means load.
REQ-007 SHALL have port i_size, input, 2 bits: 00 byte, 10 half, 11 word, 01 reserved.
REQ-008 SHALL have port i_signed, input, 1 bit: 1 sign-extends byte/half loads, 0 zero-extends them.
REQ-009 SHALL have port i_addr, input, 32 bits: byte address.
REQ-010 SHALL have port i_wdata, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have port o_busy, output, 1 bit: high from the cycle after acceptance through the o_done cycle.
REQ-012 SHALL have port o_done, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port o_rdata, output, 32 bits: extended load result, valid with o_done.
REQ-014 SHALL have ports o_err (1 bit) and o_errcode (2 bits), outputs: error flag and error code, valid with o_done; codes are 00 bad size, 01 misaligned, 10 out of range, 11 timeout.
REQ-015 SHALL have port o_mem_req, output, 1 bit: memory request, held high until ack or timeout.
REQ-016 SHALL have ports o_mem_we (1 bit), o_mem_addr (AW bits), o_mem_be (4 bits) and o_mem_wdata (32 bits), outputs: write enable, word-aligned address with bits [1:0]=0, byte-lane enables, and lane-placed write data.
REQ-017 SHALL have ports i_mem_ack (1 bit) and i_mem_rdata (32 bits), inputs: memory acknowledge, and the full read word, valid with the ack.

Function
REQ-018 SHALL implement an FSM with states IDLE, BUS and RESP.
REQ-019 SHALL, in IDLE with i_req=1, latch i_we, i_size, i_signed, i_addr and i_wdata, and assert o_busy from the next cycle.
REQ-020 SHALL check at acceptance, in priority order: bad size (i_size=01), then misaligned (half with addr[0]=1, or word with addr[1:0]!=0), then out of range (i_addr[31:AW] nonzero when AW<32).
REQ-021 SHALL, when any check fails, go to RESP with o_err=1 and the matching code, and never assert o_mem_req for that access.
REQ-022 SHALL otherwise go to BUS, driving o_mem_req=1, o_mem_addr={addr[AW-1:2],2'b00}, o_mem_we=latched we.
REQ-023 SHALL drive o_mem_be as 0001<<addr[1:0] for byte, 0011<<addr[1:0] for half, and 1111 for word, on both loads and stores.
REQ-024 SHALL, on a store, place wdata in the enabled lanes: byte is wdata[7:0] replicated four times, half is wdata[15:0] replicated twice, word is wdata unchanged.
REQ-025 SHALL use little-endian lane order for loads: byte = i_mem_rdata[8*addr[1:0] +: 8], half = i_mem_rdata[16*addr[1] +: 16], then sign- or zero-extend to 32 bits per latched i_signed.
REQ-026 SHALL, on i_mem_ack in BUS, register o_rdata (loads only; stores leave o_rdata unchanged), drop o_mem_req next cycle, and go to RESP.
REQ-027 SHALL keep a wait counter that clears on entry to BUS and increments each BUS cycle without ack.
REQ-028 SHALL, when TIMEOUT>0 and the counter reaches TIMEOUT without ack, drop o_mem_req and go to RESP with o_err=1, code 11.
REQ-029 SHALL assert o_done for exactly the one RESP cycle, then return to IDLE with o_busy=0.
REQ-030 SHALL hold o_err and o_errcode until the next acceptance, with o_err=0 on successful completion.
REQ-031 SHALL give an acceptance at cycle N with ack in cycle M >= N+1 o_done at M+1; a zero-wait ack gives o_done at N+2, and an error access gives o_done at N+1.
REQ-032 SHALL ignore i_req while o_busy=1 or in RESP; a new request is accepted at the earliest in the cycle after o_done.
REQ-033 SHALL ignore i_mem_ack outside BUS.

Reset
REQ-034 SHALL, when i_reset=1 at a rising edge, force IDLE and clear the wait counter.
REQ-035 SHALL, on reset, set o_busy, o_done, o_err, o_mem_req, o_mem_we to 0, o_errcode to 00, o_mem_be to 0000, and o_rdata, o_mem_addr, o_mem_wdata to 0.
REQ-036 SHALL, on reset mid-access, drop o_mem_req on the following cycle, produce no o_done for the aborted access, and take priority over a simultaneous i_req or i_mem_ack.

Verification
REQ-037 SHALL cover a signed byte load: addr 0x0103, i_mem_rdata 0x80AA5511, zero-wait ack -> o_mem_be 1000, o_rdata 0xFFFFFF80, o_done at N+2.
REQ-038 SHALL cover an unsigned half store then load: store wdata 0x1234ABCD to addr 0x0202 -> o_mem_be 1100, o_mem_wdata 0xABCDABCD; load with rdata 0xABCD0000 -> o_rdata 0x0000ABCD.
REQ-039 SHALL cover error checks: word load at 0x0006 -> o_err=1, code 01, o_done at N+1, o_mem_req never high; addr 0x00010000 with AW=16 -> code 10; i_size=01 -> code 00.
REQ-040 SHALL cover timeout: TIMEOUT=15 with i_mem_ack held low -> o_mem_req drops, then o_err=1, code 11; a later ack is ignored.
REQ-041 SHALL cover reset mid-access: i_reset pulsed during BUS -> all outputs 0 next cycle, no o_done, and a new request completes normally.
REQ-042 SHALL cover back-to-back traffic: i_req held high with 3-cycle ack latency -> one access per 5 cycles, none lost or duplicated.
